// File: rtl/timer_pkg.sv
// Shared types and BCD/seconds helpers for the game countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;
    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_d;
        bcd_t sec_t;
        bcd_t sec_u;
    } mss_t;

    localparam int BONUS_SEC = 10;
    localparam int MAX_MIN   = 9;

    function automatic logic [9:0] total_of(input mss_t v);
        return 10'(v.min_d) * 10'd60 + 10'(v.sec_t) * 10'd10 + 10'(v.sec_u);
    endfunction

    function automatic mss_t mss_of(input logic [9:0] t);
        mss_t       r;
        logic [9:0] rem;
        rem     = t % 10'd60;
        r.min_d = 4'(t / 10'd60);
        r.sec_t = 4'(rem / 10'd10);
        r.sec_u = 4'(rem % 10'd10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit, wrapping at 0/MAX; borrow/carry feed the next digit.
module bcd_digit
    import timer_pkg::*;
#(
    parameter int   MAX = 9,
    parameter bcd_t RST = '0
) (
    input  logic clk,
    input  logic resetN,
    input  logic dec,
    input  logic inc,
    input  logic load,
    input  bcd_t ld_val,
    output bcd_t value,
    output logic borrow_out,
    output logic carry_out
);

    assign borrow_out = dec && (value == '0);
    assign carry_out  = inc && (value == bcd_t'(MAX));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            value <= RST;
        else if (load)
            value <= ld_val;
        else if (dec)
            value <= borrow_out ? bcd_t'(MAX) : value - 4'd1;
        else if (inc)
            value <= carry_out ? '0 : value + 4'd1;
    end

endmodule

// File: rtl/countdown_timer.sv
// Game countdown clock: M:SS BCD value decremented per one-second tick,
// with pause, bonus time, time-up pulse and low-time warning/blanking.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int INIT_MIN = 2,
    parameter int INIT_SEC = 0,
    parameter int WARN_SEC = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       duty50,
    input  logic       start,
    input  logic       pause,
    input  logic       bonus,
    output logic [3:0] min_d,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       time_up,
    output logic       warn,
    output logic       blank
);

    localparam logic [9:0] INIT_TOT = 10'(INIT_MIN * 60 + INIT_SEC);
    localparam logic [9:0] MAX_TOT  = 10'(MAX_MIN * 60 + 59);
    localparam mss_t       INIT_V   = mss_of(INIT_TOT);

    timer_state_t state, nxt_state;
    mss_t         cur, ld_val;
    logic [9:0]   total, nxt_total;
    logic [10:0]  bon_sum, tb_sum;
    logic         dec, inc, ld, run_dec, bon_ok;
    logic         su_borrow, st_borrow, st_carry;
    logic         unused_su_carry, unused_min_borrow, unused_min_carry;

    assign cur     = {min_d, sec_t, sec_u};
    assign total   = total_of(cur);
    assign bon_sum = {1'b0, total} + 11'(BONUS_SEC);
    assign tb_sum  = {1'b0, total} + 11'(BONUS_SEC - 1);
    assign run_dec = tick && (state == RUN) && (total != '0);
    assign bon_ok  = bonus && (state != EXPIRED);

    always_comb begin
        nxt_state = state;
        nxt_total = total;
        dec       = 1'b0;
        inc       = 1'b0;
        ld        = 1'b0;
        ld_val    = cur;
        if (start) begin
            // IDLE keeps the preset value; every other state restarts from INIT
            if (state != IDLE) begin
                ld        = 1'b1;
                ld_val    = INIT_V;
                nxt_total = INIT_TOT;
            end
            nxt_state = (nxt_total == '0) ? EXPIRED : RUN;
        end else if (pause && (state == RUN || state == PAUSED)) begin
            nxt_state = (state == RUN) ? PAUSED : RUN;
        end else if (run_dec && bon_ok) begin
            // net +9 s, cannot reach zero since total was non-zero
            ld        = 1'b1;
            nxt_total = (tb_sum > 11'(MAX_TOT)) ? MAX_TOT : tb_sum[9:0];
            ld_val    = mss_of(nxt_total);
        end else if (run_dec) begin
            dec       = 1'b1;
            nxt_total = total - 10'd1;
            if (nxt_total == '0)
                nxt_state = EXPIRED;
        end else if (bon_ok) begin
            if (bon_sum > 11'(MAX_TOT)) begin
                ld        = 1'b1;
                ld_val    = mss_of(MAX_TOT);
                nxt_total = MAX_TOT;
            end else begin
                inc       = 1'b1;
                nxt_total = bon_sum[9:0];
            end
        end
    end

    bcd_digit #(.MAX(9), .RST(INIT_V.sec_u)) u_sec_u (
        .clk(clk), .resetN(resetN), .dec(dec), .inc(1'b0), .load(ld),
        .ld_val(ld_val.sec_u), .value(sec_u),
        .borrow_out(su_borrow), .carry_out(unused_su_carry)
    );

    bcd_digit #(.MAX(5), .RST(INIT_V.sec_t)) u_sec_t (
        .clk(clk), .resetN(resetN), .dec(su_borrow), .inc(inc), .load(ld),
        .ld_val(ld_val.sec_t), .value(sec_t),
        .borrow_out(st_borrow), .carry_out(st_carry)
    );

    bcd_digit #(.MAX(9), .RST(INIT_V.min_d)) u_min_d (
        .clk(clk), .resetN(resetN), .dec(st_borrow), .inc(st_carry), .load(ld),
        .ld_val(ld_val.min_d), .value(min_d),
        .borrow_out(unused_min_borrow), .carry_out(unused_min_carry)
    );

    // flags are registered from next-state values so they align with the digits
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            running <= 1'b0;
            time_up <= 1'b0;
            warn    <= 1'b0;
        end else begin
            state   <= nxt_state;
            running <= (nxt_state == RUN);
            time_up <= (nxt_state == EXPIRED) && (state != EXPIRED);
            warn    <= (nxt_state == RUN) && (nxt_total <= 10'(WARN_SEC));
        end
    end

    assign blank = warn & ~duty50;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: three timer instances (2:00, 0:03, 1:00 presets) on shared inputs.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic resetN, tick, duty50, start, pause, bonus;
    logic [3:0] a_m, a_t, a_u, b_m, b_t, b_u, c_m, c_t, c_u;
    logic a_run, a_up, a_warn, a_blank;
    logic b_run, b_up, b_warn, b_blank;
    logic c_run, c_up, c_warn, c_blank;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    countdown_timer dut_a (
        .clk(clk), .resetN(resetN), .tick(tick), .duty50(duty50), .start(start),
        .pause(pause), .bonus(bonus), .min_d(a_m), .sec_t(a_t), .sec_u(a_u),
        .running(a_run), .time_up(a_up), .warn(a_warn), .blank(a_blank)
    );

    countdown_timer #(.INIT_MIN(0), .INIT_SEC(3), .WARN_SEC(10)) dut_b (
        .clk(clk), .resetN(resetN), .tick(tick), .duty50(duty50), .start(start),
        .pause(pause), .bonus(bonus), .min_d(b_m), .sec_t(b_t), .sec_u(b_u),
        .running(b_run), .time_up(b_up), .warn(b_warn), .blank(b_blank)
    );

    countdown_timer #(.INIT_MIN(1), .INIT_SEC(0), .WARN_SEC(10)) dut_c (
        .clk(clk), .resetN(resetN), .tick(tick), .duty50(duty50), .start(start),
        .pause(pause), .bonus(bonus), .min_d(c_m), .sec_t(c_t), .sec_u(c_u),
        .running(c_run), .time_up(c_up), .warn(c_warn), .blank(c_blank)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // apply one cycle of inputs, then settle 1 time unit past the edge
    task automatic cyc(input logic t, input logic s, input logic p, input logic b);
        tick = t; start = s; pause = p; bonus = b;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; pause = 1'b0; bonus = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        resetN = 1'b0; tick = 1'b0; duty50 = 1'b0;
        start = 1'b0; pause = 1'b0; bonus = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_val", {a_m, a_t, a_u}, 16'h200);
        chk("rst_b_val", {b_m, b_t, b_u}, 16'h003);
        chk("rst_c_val", {c_m, c_t, c_u}, 16'h100);
        chk("rst_flags", {a_run, a_up, a_warn, a_blank}, 16'h0);
        resetN = 1'b1;

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_a_val", {a_m, a_t, a_u}, 16'h200);
        chk("start_a_run", a_run, 1'b1);
        chk("start_b_run", b_run, 1'b1);

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b_tick2_up", b_up, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_3ticks_val", {a_m, a_t, a_u}, 16'h157);
        chk("a_3ticks_flags", {a_run, a_up}, 2'b10);
        chk("b_expire_val", {b_m, b_t, b_u}, 16'h000);
        chk("b_expire_up", b_up, 1'b1);
        chk("b_expire_run", b_run, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("b_up_oneshot", b_up, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b_tick4_val", {b_m, b_t, b_u}, 16'h000);
        chk("b_tick4_up", b_up, 1'b0);

        // a is at 1:56 -> run down to 0:40
        repeat (76) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_at_040", {a_m, a_t, a_u}, 16'h040);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_run", a_run, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("paused_hold", {a_m, a_t, a_u}, 16'h040);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_run", a_run, 1'b1);
        chk("resume_val", {a_m, a_t, a_u}, 16'h040);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_tick", {a_m, a_t, a_u}, 16'h039);

        // 0:35 paused, bonus up to 9:55 then saturate
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (56) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bonus_955", {a_m, a_t, a_u}, 16'h955);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bonus_sat", {a_m, a_t, a_u}, 16'h959);

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (544) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_at_055", {a_m, a_t, a_u}, 16'h055);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("tick_bonus", {a_m, a_t, a_u}, 16'h104);

        repeat (52) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_at_012", {a_m, a_t, a_u}, 16'h012);
        chk("warn_012", a_warn, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("warn_011", a_warn, 1'b0);
        chk("blank_011", a_blank, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("warn_010_val", {a_m, a_t, a_u}, 16'h010);
        chk("warn_010", a_warn, 1'b1);
        chk("blank_lo", a_blank, 1'b1);
        duty50 = 1'b1;
        #1;
        chk("blank_hi", a_blank, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("warn_009", a_warn, 1'b1);
        duty50 = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("warn_paused", a_warn, 1'b0);
        chk("blank_paused", a_blank, 1'b0);

        // resume at 0:09, +30 s, down to 0:30 then async reset
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_at_030", {a_m, a_t, a_u, 3'b000, a_run}, {12'h030, 4'h1});
        resetN = 1'b0;
        #1;
        chk("rst_mid_val", {a_m, a_t, a_u}, 16'h200);
        chk("rst_mid_flags", {a_run, a_up, a_warn}, 3'b000);
        @(posedge clk);
        #1;
        chk("rst_mid_noup", a_up, 1'b0);
        resetN = 1'b1;

        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("c_start_tick", {c_m, c_t, c_u}, 16'h100);
        chk("c_start_run", c_run, 1'b1);
        chk("a_start_tick", {a_m, a_t, a_u}, 16'h200);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("c_first_dec", {c_m, c_t, c_u}, 16'h059);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
